// File: rtl/vx_lane_splitter.sv
// vx_lane_splitter: serialises one full-warp operand bundle (NUM_THREADS lanes) into
// NUM_THREADS/NUM_LANES execute packets of NUM_LANES lanes each, tagged with pid/sop/eop.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_tmask, in_rs1_data..in_rs3_data, in_meta : warp bundle input
//   out_valid/out_ready, out_tmask, out_rs1_data..out_rs3_data,
//   out_meta, out_pid, out_sop, out_eop                             : lane-group packet output
//
// Configuration macro: VX_LANE_SPLIT_SKIP_EMPTY_EN
//   When defined, lane groups with an all-zero tmask slice are not emitted (an all-zero
//   warp still produces exactly one packet with pid=0). When undefined, every group is emitted.
module vx_lane_splitter #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned META_WIDTH  = 64,
  localparam int unsigned PID_COUNT  = NUM_THREADS / NUM_LANES,
  localparam int unsigned PID_WIDTH  = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  input  logic [META_WIDTH-1:0]       in_meta,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
  output logic [META_WIDTH-1:0]       out_meta,
  output logic [PID_WIDTH-1:0]        out_pid,
  output logic                        out_sop,
  output logic                        out_eop
);

  typedef enum logic [0:0] {StIdle, StSplit} state_e;

  state_e                      state_q;
  logic [PID_WIDTH-1:0]        pid_q;
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [META_WIDTH-1:0]       meta_q;

  logic                        accept;
  logic [PID_WIDTH-1:0]        in_first;
  logic [PID_WIDTH-1:0]        buf_first;
  logic [PID_WIDTH-1:0]        buf_last;
  logic [PID_WIDTH-1:0]        pid_next;

`ifdef VX_LANE_SPLIT_SKIP_EMPTY_EN
  // One bit per lane group: set when any thread of the group is active.
  function automatic logic [PID_COUNT-1:0] group_nz(input logic [NUM_THREADS-1:0] m);
    group_nz = '0;
    for (int g = 0; g < int'(PID_COUNT); g++) begin
      group_nz[g] = |m[g*NUM_LANES +: NUM_LANES];
    end
  endfunction

  // Lowest active group; 0 for an empty mask so an empty warp still yields one packet.
  function automatic logic [PID_WIDTH-1:0] first_grp(input logic [NUM_THREADS-1:0] m);
    logic [PID_COUNT-1:0] nz;
    nz = group_nz(m);
    first_grp = '0;
    for (int g = int'(PID_COUNT) - 1; g >= 0; g--) begin
      if (nz[g]) first_grp = PID_WIDTH'(g);
    end
  endfunction

  function automatic logic [PID_WIDTH-1:0] last_grp(input logic [NUM_THREADS-1:0] m);
    logic [PID_COUNT-1:0] nz;
    nz = group_nz(m);
    last_grp = '0;
    for (int g = 0; g < int'(PID_COUNT); g++) begin
      if (nz[g]) last_grp = PID_WIDTH'(g);
    end
  endfunction

  // Next active group above pid; only consulted when pid is not the last group,
  // so an active group above it always exists.
  function automatic logic [PID_WIDTH-1:0] next_grp(input logic [NUM_THREADS-1:0] m,
                                                    input logic [PID_WIDTH-1:0]   pid);
    logic [PID_COUNT-1:0] nz;
    nz = group_nz(m);
    next_grp = pid;
    for (int g = int'(PID_COUNT) - 1; g >= 0; g--) begin
      if (nz[g] && (g > int'(pid))) next_grp = PID_WIDTH'(g);
    end
  endfunction

  assign in_first  = first_grp(in_tmask);
  assign buf_first = first_grp(tmask_q);
  assign buf_last  = last_grp(tmask_q);
  assign pid_next  = next_grp(tmask_q, pid_q);
`else
  assign in_first  = '0;
  assign buf_first = '0;
  assign buf_last  = PID_WIDTH'(PID_COUNT - 1);
  assign pid_next  = pid_q + 1'b1;
`endif

  assign out_valid = (state_q == StSplit);
  assign out_pid   = pid_q;
  assign out_sop   = (pid_q == buf_first);
  assign out_eop   = (pid_q == buf_last);
  assign out_meta  = meta_q;

  // Accepting on the eop handshake lets a new warp follow with no bubble.
  assign in_ready = reset & ((state_q == StIdle) | (out_valid & out_ready & out_eop));
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_tmask    = '0;
    out_rs1_data = '0;
    out_rs2_data = '0;
    out_rs3_data = '0;
    for (int g = 0; g < int'(PID_COUNT); g++) begin
      if (pid_q == PID_WIDTH'(g)) begin
        out_tmask    = tmask_q[g*NUM_LANES +: NUM_LANES];
        out_rs1_data = rs1_q[g*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        out_rs2_data = rs2_q[g*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        out_rs3_data = rs3_q[g*NUM_LANES*XLEN +: NUM_LANES*XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pid_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StSplit;
            pid_q   <= in_first;
          end
        end
        StSplit: begin
          if (out_ready) begin
            if (!out_eop) begin
              pid_q <= pid_next;
            end else if (accept) begin
              pid_q <= in_first;
            end else begin
              state_q <= StIdle;
              pid_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          pid_q   <= '0;
        end
      endcase
    end
  end

  // Warp buffer carries no reset; its contents only matter while in StSplit.
  always_ff @(posedge clk) begin
    if (accept) begin
      tmask_q <= in_tmask;
      rs1_q   <= in_rs1_data;
      rs2_q   <= in_rs2_data;
      rs3_q   <= in_rs3_data;
      meta_q  <= in_meta;
    end
  end

endmodule

// File: tb/tb_vx_lane_splitter.sv
// Self-checking bench for vx_lane_splitter: directed scenarios followed by random traffic,
// all checked against a packet-queue reference model of the warp-splitting rules.
module tb_vx_lane_splitter;

  localparam int NT  = 4;
  localparam int NL  = 2;
  localparam int XL  = 32;
  localparam int MW  = 64;
  localparam int PC  = NT / NL;
  localparam int PW  = (PC > 1) ? $clog2(PC) : 1;
  localparam int PKW = NL * XL;

`ifdef VX_LANE_SPLIT_SKIP_EMPTY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [NT-1:0]     in_tmask;
  logic [NT*XL-1:0]  in_rs1_data, in_rs2_data, in_rs3_data;
  logic [MW-1:0]     in_meta;
  logic              out_valid, out_ready;
  logic [NL-1:0]     out_tmask;
  logic [PKW-1:0]    out_rs1_data, out_rs2_data, out_rs3_data;
  logic [MW-1:0]     out_meta;
  logic [PW-1:0]     out_pid;
  logic              out_sop, out_eop;

  typedef struct packed {
    logic [NL-1:0]  tmask;
    logic [PKW-1:0] rs1;
    logic [PKW-1:0] rs2;
    logic [PKW-1:0] rs3;
    logic [MW-1:0]  meta;
    logic [PW-1:0]  pid;
    logic           sop;
    logic           eop;
  } pkt_t;

  pkt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   acc;

  logic [NT-1:0]    nxt_tmask;
  logic [NT*XL-1:0] nxt_rs1, nxt_rs2, nxt_rs3;
  logic [MW-1:0]    nxt_meta;

  vx_lane_splitter #(
    .NUM_THREADS(NT),
    .NUM_LANES  (NL),
    .XLEN       (XL),
    .META_WIDTH (MW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_tmask    (in_tmask),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .in_rs3_data (in_rs3_data),
    .in_meta     (in_meta),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_tmask   (out_tmask),
    .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data),
    .out_rs3_data(out_rs3_data),
    .out_meta    (out_meta),
    .out_pid     (out_pid),
    .out_sop     (out_sop),
    .out_eop     (out_eop)
  );

  always #5 clk = ~clk;

  // Reference: list the groups that must be emitted, then one packet per listed group.
  function automatic void push_warp();
    int   grps[$];
    pkt_t p;
    for (int g = 0; g < PC; g++) begin
      if (!SKIP || (NL'(in_tmask >> (g * NL)) != '0)) grps.push_back(g);
    end
    if (grps.size() == 0) grps.push_back(0);
    for (int i = 0; i < grps.size(); i++) begin
      p.tmask = NL'(in_tmask >> (grps[i] * NL));
      p.rs1   = PKW'(in_rs1_data >> (grps[i] * PKW));
      p.rs2   = PKW'(in_rs2_data >> (grps[i] * PKW));
      p.rs3   = PKW'(in_rs3_data >> (grps[i] * PKW));
      p.meta  = in_meta;
      p.pid   = PW'(grps[i]);
      p.sop   = (i == 0);
      p.eop   = (i == grps.size() - 1);
      exp_q.push_back(p);
    end
  endfunction

  task automatic set_warp(input logic [NT-1:0] tm, input logic [NT*XL-1:0] r1,
                          input logic [NT*XL-1:0] r2, input logic [NT*XL-1:0] r3,
                          input logic [MW-1:0] meta);
    nxt_tmask = tm;
    nxt_rs1   = r1;
    nxt_rs2   = r2;
    nxt_rs3   = r3;
    nxt_meta  = meta;
  endtask

  task automatic rand_warp(input logic [NT-1:0] tm);
    for (int i = 0; i < NT; i++) begin
      nxt_rs1[i*XL +: XL] = $urandom;
      nxt_rs2[i*XL +: XL] = $urandom;
      nxt_rs3[i*XL +: XL] = $urandom;
    end
    nxt_tmask = tm;
    nxt_meta  = {$urandom, $urandom};
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later, update the model.
  task automatic step(input bit iv, input bit ordy);
    pkt_t got;
    bit   exp_ov, exp_ir, pop;
    @(negedge clk);
    in_valid    = iv;
    out_ready   = ordy;
    in_tmask    = nxt_tmask;
    in_rs1_data = nxt_rs1;
    in_rs2_data = nxt_rs2;
    in_rs3_data = nxt_rs3;
    in_meta     = nxt_meta;
    #1;
    exp_ov = reset && (exp_q.size() != 0);
    exp_ir = reset && ((exp_q.size() == 0) || ((exp_q.size() == 1) && ordy));
    checks++;
    assert (out_valid === exp_ov) else begin
      errors++;
      $error("FAIL out_valid got=%b exp=%b", out_valid, exp_ov);
    end
    checks++;
    assert (in_ready === exp_ir) else begin
      errors++;
      $error("FAIL in_ready got=%b exp=%b", in_ready, exp_ir);
    end
    if (exp_ov) begin
      got.tmask = out_tmask;
      got.rs1   = out_rs1_data;
      got.rs2   = out_rs2_data;
      got.rs3   = out_rs3_data;
      got.meta  = out_meta;
      got.pid   = out_pid;
      got.sop   = out_sop;
      got.eop   = out_eop;
      checks++;
      assert (got === exp_q[0]) else begin
        errors++;
        $error("FAIL packet got=%h exp=%h", got, exp_q[0]);
      end
    end
    pop = exp_ov && ordy;
    acc = iv && exp_ir;
    if (pop) void'(exp_q.pop_front());
    if (acc) push_warp();
  endtask

  task automatic send(input bit ordy);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, ordy);
      if (acc) break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_warp('0, '0, '0, '0, '0);

    // Reset state: no valid, no ready.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    reset = 1'b1;

    // Basic split, rs1 lanes {4,3,2,1}.
    set_warp(4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
             {32'h400, 32'h300, 32'h200, 32'h100}, 64'hdead_beef_0000_0001);
    send(1'b1);
    drain();

    // Back-to-back warps with in_valid held.
    rand_warp(4'b1111);
    send(1'b1);
    rand_warp(4'b1011);
    send(1'b1);
    drain();

    // Backpressure during beat0.
    rand_warp(4'b0111);
    send(1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    drain();

    // Partial mask and empty mask.
    rand_warp(4'b1100);
    send(1'b1);
    drain();
    rand_warp(4'b0011);
    send(1'b1);
    drain();
    rand_warp(4'b0000);
    send(1'b1);
    drain();

    // Reset mid-warp after the beat0 handshake.
    rand_warp(4'b1111);
    send(1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    assert (out_valid === 1'b0) else begin
      errors++;
      $error("FAIL rst_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    assert (in_ready === 1'b0) else begin
      errors++;
      $error("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    exp_q.delete();
    step(1'b0, 1'b1);
    reset = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Random traffic.
    rand_warp(NT'($urandom));
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0);
      if (acc) rand_warp(NT'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_lane_splitter.md
Name: vx_lane_splitter

Overview:
- Upstream neighbour of the execute-stage packet interface.
- Accepts one full-warp operand bundle (NUM_THREADS lanes) and serialises it into NUM_THREADS/NUM_LANES execute packets of NUM_LANES lanes each.
- Tags each packet with pid/sop/eop so functional units can process a warp in lane-group slices.
- Sits between operand collection and the per-unit execute ports.

Parameters:
NUM_THREADS, 4, lanes per warp on input (power of two)
NUM_LANES, 2, lanes per output packet (power of two, divides NUM_THREADS)
XLEN, 32, operand width
META_WIDTH, 64, width of opaque packed metadata (uuid, wid, PC, op_type, op_args, wb, rd, tid) passed through unchanged
PID_COUNT (derived), NUM_THREADS/NUM_LANES
PID_WIDTH (derived), LOG2UP(PID_COUNT)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  warp bundle valid
in_ready  out  1  warp bundle accepted when in_valid & in_ready
in_tmask  in  NUM_THREADS  thread mask
in_rs1_data  in  NUM_THREADS*XLEN  operand 1, lane i at bits [i*XLEN +: XLEN]
in_rs2_data  in  NUM_THREADS*XLEN  operand 2
in_rs3_data  in  NUM_THREADS*XLEN  operand 3
in_meta  in  META_WIDTH  passthrough metadata
out_valid  out  1  packet valid
out_ready  in  1  packet consumed when out_valid & out_ready
out_tmask  out  NUM_LANES  slice of tmask for current pid
out_rs1_data  out  NUM_LANES*XLEN  slice of operand 1
out_rs2_data  out  NUM_LANES*XLEN  slice of operand 2
out_rs3_data  out  NUM_LANES*XLEN  slice of operand 3
out_meta  out  META_WIDTH  captured metadata
out_pid  out  PID_WIDTH  lane-group index
out_sop  out  1  first packet of warp
out_eop  out  1  last packet of warp

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-low; all state clears immediately on assertion.
- Reset values: state=IDLE, pid=0, out_valid=0, in_ready=0 while reset is low. Data buffers are don't-care.
- Storage: one warp buffer holding tmask, rs1..rs3 and meta, plus a pid counter.
- IDLE state:
  - in_ready=1, out_valid=0.
  - On in_valid handshake: capture the bundle, set pid=first, go to SPLIT.
- SPLIT state:
  - out_valid=1. Outputs are the lane group pid: lanes [pid*NUM_LANES +: NUM_LANES] of the buffer.
  - out_sop=(pid==first); out_eop=(pid==last).
  - On out handshake with eop=0: pid advances to the next emitted group.
  - On out handshake with eop=1: if in_valid, capture the new bundle in the same cycle and stay in SPLIT with pid=first (no bubble). Otherwise go to IDLE.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_eop). This is a combinational out_ready to in_ready path and is permitted.
- Backpressure: while out_valid & !out_ready, all out_* fields hold stable.
- Latency and throughput:
  - Input-to-first-packet latency is 1 cycle (registered output).
  - Throughput is PID_COUNT packets per warp at full rate.
- PID_COUNT==1: first=last=0, sop=eop=1, pid=0. The block degenerates to a single registered stage with full throughput.
- pid arithmetic: unsigned, never exceeds PID_COUNT-1, no wrap past last.
- Default (feature off): first=0, last=PID_COUNT-1. Every group is emitted, including groups with an all-zero tmask.

Optional Feature:
- Macro: VX_LANE_SPLIT_SKIP_EMPTY_EN.
- Defined:
  - first = lowest group with a nonzero tmask slice; last = highest such group.
  - Groups between first and last whose slice is zero are skipped; pid jumps directly to the next nonzero group.
  - If the whole tmask is zero, exactly one packet is emitted: pid=0, sop=eop=1, tmask=0.
- Undefined: all PID_COUNT groups are emitted, as in the default behaviour.

Test Plan:
1. Basic split (NUM_THREADS=4, NUM_LANES=2, out_ready=1). Stimulus: tmask=4'b1111, rs1 lanes {4,3,2,1}. Required response: beat0 pid=0 sop=1 eop=0 tmask=2'b11 rs1={2,1}; beat1 pid=1 sop=0 eop=1 rs1={4,3}; in_ready=1 in the beat1 cycle.
2. Back-to-back warps. Stimulus: in_valid held with warps A and B. Required response: 4 consecutive out beats A0, A1, B0, B1 with no idle cycle; B captured on the A1 handshake.
3. Backpressure. Stimulus: out_ready=0 for 3 cycles during beat0. Required response: out_* constant, in_ready=0; beat1 appears the cycle after out_ready rises.
4. Partial mask. Stimulus: tmask=4'b1100. Required response: with VX_LANE_SPLIT_SKIP_EMPTY_EN, a single beat pid=1 sop=1 eop=1 tmask=2'b11; without it, two beats with beat0 tmask=2'b00.
5. Empty mask with feature on. Stimulus: tmask=4'b0000. Required response: one beat pid=0 sop=1 eop=1 tmask=2'b00, then IDLE.
6. Reset mid-warp. Stimulus: reset driven low after the beat0 handshake. Required response: out_valid=0 immediately (asynchronous); after release, in_ready=1 and no stale beat1 is emitted.
